// File: rtl/lsu_dbus_master.sv
// Data-bus initiator for the LSU: issues one load/store at a time, builds byte lanes,
// waits for the peripheral acknowledge and returns extended load data or an error flag.

package lsu_dbus_pkg;
    typedef struct packed {
        logic        req;
        logic        w_en;
        logic [31:0] addr;
        logic [31:0] w_data;
        logic [3:0]  sel_byte;
    } type_dbus2peri_s;

    typedef struct packed {
        logic [31:0] r_data;
        logic        ack;
    } type_peri2dbus_s;
endpackage

module lsu_dbus_master #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          op_valid,
    output logic                          op_ready,
    input  logic                          op_store,
    input  logic [1:0]                    op_size,
    input  logic                          op_unsigned,
    input  logic [XLEN-1:0]               op_addr,
    input  logic [XLEN-1:0]               op_wdata,
    output lsu_dbus_pkg::type_dbus2peri_s lsu2dbus_o,
    input  lsu_dbus_pkg::type_peri2dbus_s dbus2lsu_i,
    output logic                          rsp_valid,
    output logic [XLEN-1:0]               rsp_rdata,
    output logic                          rsp_misaligned,
    output logic                          rsp_timeout
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast =
        CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e                        state_q;
    logic                          store_q;
    logic                          unsigned_q;
    logic [1:0]                    size_q;
    logic [1:0]                    off_q;
    logic [CntW-1:0]               cnt_q;
    lsu_dbus_pkg::type_dbus2peri_s bus_q;
    logic                          rsp_valid_q;
    logic                          rsp_mis_q;
    logic                          rsp_to_q;
    logic [XLEN-1:0]               rsp_rdata_q;

    logic            misaligned;
    logic [3:0]      sel_d;
    logic [XLEN-1:0] wdata_d;
    logic [7:0]      ld_b;
    logic [15:0]     ld_h;
    logic [XLEN-1:0] ld_ext;

    always_comb begin
        misaligned = 1'b1;
        sel_d      = 4'b1111;
        wdata_d    = op_wdata;
        unique case (op_size)
            2'b00: begin
                misaligned = 1'b0;
                sel_d      = 4'b0001 << op_addr[1:0];
                wdata_d    = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = op_addr[0];
                sel_d      = op_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d    = {2{op_wdata[15:0]}};
            end
            2'b10:   misaligned = |op_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        ld_b   = dbus2lsu_i.r_data[{off_q, 3'b000} +: 8];
        ld_h   = dbus2lsu_i.r_data[{off_q[1], 4'b0000} +: 16];
        ld_ext = dbus2lsu_i.r_data;
        unique case (size_q)
            2'b00:   ld_ext = unsigned_q ? {{(XLEN-8){1'b0}}, ld_b}
                                         : {{(XLEN-8){ld_b[7]}}, ld_b};
            2'b01:   ld_ext = unsigned_q ? {{(XLEN-16){1'b0}}, ld_h}
                                         : {{(XLEN-16){ld_h[15]}}, ld_h};
            default: ld_ext = dbus2lsu_i.r_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            store_q     <= 1'b0;
            unsigned_q  <= 1'b0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            cnt_q       <= '0;
            bus_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_mis_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (op_valid) begin
                        store_q    <= op_store;
                        unsigned_q <= op_unsigned;
                        size_q     <= op_size;
                        off_q      <= op_addr[1:0];
                        if (misaligned) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_mis_q   <= 1'b1;
                        end else begin
                            state_q        <= StReq;
                            cnt_q          <= '0;
                            bus_q.req      <= 1'b1;
                            bus_q.w_en     <= op_store;
                            bus_q.addr     <= {op_addr[XLEN-1:2], 2'b00};
                            bus_q.w_data   <= wdata_d;
                            bus_q.sel_byte <= sel_d;
                        end
                    end
                end
                StReq: begin
                    // Ack takes priority over a timeout expiring in the same cycle.
                    if (dbus2lsu_i.ack) begin
                        state_q     <= StResp;
                        bus_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= store_q ? '0 : ld_ext;
                    end else if (TIMEOUT_CYCLES != 0 && cnt_q == CntLast) begin
                        state_q     <= StResp;
                        bus_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_to_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StResp: begin
                    state_q     <= StIdle;
                    rsp_valid_q <= 1'b0;
                    rsp_mis_q   <= 1'b0;
                    rsp_to_q    <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign op_ready       = (state_q == StIdle) && rst_n;
    assign lsu2dbus_o     = bus_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_misaligned = rsp_mis_q;
    assign rsp_timeout    = rsp_to_q;

endmodule

// File: tb/tb_lsu_dbus_master.sv
// Directed bench for lsu_dbus_master: a small word memory answers the bus with
// combinational, registered, delayed or absent acknowledges.

module tb_lsu_dbus_master;
    import lsu_dbus_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (timeout of 4 cycles)
    logic            op_valid = 1'b0, op_store = 1'b0, op_unsigned = 1'b0;
    logic [1:0]      op_size = 2'b00;
    logic [31:0]     op_addr = '0, op_wdata = '0;
    logic            op_ready, rsp_valid, rsp_mis, rsp_to;
    logic [31:0]     rsp_rdata;
    type_dbus2peri_s bus;
    type_peri2dbus_s pres;

    // Second DUT with the timeout disabled, never acknowledged
    logic            op0_valid = 1'b0;
    logic            op0_ready, rsp0_valid, rsp0_mis, rsp0_to;
    logic [31:0]     rsp0_rdata;
    type_dbus2peri_s bus0;
    type_peri2dbus_s pres0;

    lsu_dbus_master #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_store(op_store), .op_size(op_size), .op_unsigned(op_unsigned),
        .op_addr(op_addr), .op_wdata(op_wdata), .lsu2dbus_o(bus), .dbus2lsu_i(pres),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_misaligned(rsp_mis),
        .rsp_timeout(rsp_to)
    );

    lsu_dbus_master #(.XLEN(32), .TIMEOUT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .op_valid(op0_valid), .op_ready(op0_ready),
        .op_store(1'b0), .op_size(2'b10), .op_unsigned(1'b0),
        .op_addr(32'h0000_0100), .op_wdata(32'h0), .lsu2dbus_o(bus0), .dbus2lsu_i(pres0),
        .rsp_valid(rsp0_valid), .rsp_rdata(rsp0_rdata), .rsp_misaligned(rsp0_mis),
        .rsp_timeout(rsp0_to)
    );

    assign pres0.ack    = 1'b0;
    assign pres0.r_data = 32'h0;

    // Memory model: ack_mode 0 = same cycle, 1 = 2nd req cycle, 2 = never, 3 = 4th req cycle
    logic [31:0] mem [0:255];
    int          ack_mode = 0;
    int          req_cnt = 0;
    logic        ack;

    always_comb begin
        ack = 1'b0;
        case (ack_mode)
            0: ack = bus.req;
            1: ack = bus.req && (req_cnt == 1);
            3: ack = bus.req && (req_cnt == 3);
            default: ack = 1'b0;
        endcase
    end
    assign pres.ack    = ack;
    assign pres.r_data = mem[bus.addr[9:2]];

    always @(posedge clk) begin
        req_cnt <= bus.req ? req_cnt + 1 : 0;
        if (bus.req && bus.w_en) begin
            for (int l = 0; l < 4; l++)
                if (bus.sel_byte[l]) mem[bus.addr[9:2]][8*l +: 8] <= bus.w_data[8*l +: 8];
        end
    end

    int checks = 0, errors = 0;

    // Results of the most recent operation
    int          r_lat, r_reqc;
    logic [31:0] r_rdata, r_wd;
    logic [3:0]  r_sel;
    logic        r_mis, r_to, r_en, r_busy_ready;

    task automatic run_op(input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        bit got;
        @(negedge clk);
        op_store = st; op_size = sz; op_unsigned = uns; op_addr = addr; op_wdata = wd;
        op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        op_addr = 32'hFFFF_FFFF; op_wdata = 32'hFFFF_FFFF; op_size = 2'b11;
        r_lat = 0; r_reqc = 0; r_busy_ready = 1'b0; got = 1'b0;
        r_rdata = 'x; r_mis = 1'bx; r_to = 1'bx; r_sel = 'x; r_wd = 'x; r_en = 1'bx;
        while (!got && r_lat < 50) begin
            @(negedge clk);
            r_lat++;
            if (op_ready) r_busy_ready = 1'b1;
            if (bus.req) begin
                if (r_reqc == 0) begin r_sel = bus.sel_byte; r_wd = bus.w_data; r_en = bus.w_en; end
                r_reqc++;
            end
            if (rsp_valid) begin
                got = 1'b1; r_rdata = rsp_rdata; r_mis = rsp_mis; r_to = rsp_to;
            end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL rsp_bound: no rsp_valid within %0d cycles", r_lat); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", op_ready); end
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", bus.req); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp: got %b exp 0", rsp_valid); end
        rst_n = 1'b1;
        #1;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b exp 1", op_ready); end
    endtask

    task automatic test_loads();
        ack_mode = 0;
        run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        checks++; if (r_rdata !== 32'h8899AABB) begin errors++; $display("FAIL lw_data: got %h exp 8899aabb", r_rdata); end
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d exp 2", r_lat); end
        checks++; if (r_reqc !== 1) begin errors++; $display("FAIL lw_req_cycles: got %0d exp 1", r_reqc); end
        checks++; if (r_busy_ready !== 1'b0) begin errors++; $display("FAIL lw_busy_ready: got %b exp 0", r_busy_ready); end
        run_op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
        checks++; if (r_rdata !== 32'hFFFFFF88) begin errors++; $display("FAIL lb_data: got %h exp ffffff88", r_rdata); end
        run_op(1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
        checks++; if (r_rdata !== 32'h00008899) begin errors++; $display("FAIL lhu_data: got %h exp 00008899", r_rdata); end
        run_op(1'b0, 2'b01, 1'b0, 32'h100, 32'h0);
        checks++; if (r_rdata !== 32'hFFFFAABB) begin errors++; $display("FAIL lh_data: got %h exp ffffaabb", r_rdata); end
    endtask

    task automatic test_stores();
        ack_mode = 1;
        run_op(1'b1, 2'b00, 1'b0, 32'h205, 32'h12345678);
        checks++; if (r_sel !== 4'b0010) begin errors++; $display("FAIL sb_sel: got %b exp 0010", r_sel); end
        checks++; if (r_wd !== 32'h78787878) begin errors++; $display("FAIL sb_wdata: got %h exp 78787878", r_wd); end
        checks++; if (r_lat !== 3) begin errors++; $display("FAIL sb_latency: got %0d exp 3", r_lat); end
        checks++; if (r_en !== 1'b1) begin errors++; $display("FAIL sb_wen: got %b exp 1", r_en); end
        checks++; if (r_rdata !== 32'h0) begin errors++; $display("FAIL sb_rdata: got %h exp 0", r_rdata); end
        run_op(1'b1, 2'b01, 1'b0, 32'h206, 32'h12345678);
        checks++; if (r_sel !== 4'b1100) begin errors++; $display("FAIL sh_sel: got %b exp 1100", r_sel); end
        checks++; if (r_wd !== 32'h56785678) begin errors++; $display("FAIL sh_wdata: got %h exp 56785678", r_wd); end
        checks++; if (r_lat !== 3) begin errors++; $display("FAIL sh_latency: got %0d exp 3", r_lat); end
        run_op(1'b1, 2'b10, 1'b0, 32'h208, 32'h12345678);
        checks++; if (r_sel !== 4'b1111) begin errors++; $display("FAIL sw_sel: got %b exp 1111", r_sel); end
        checks++; if (r_wd !== 32'h12345678) begin errors++; $display("FAIL sw_wdata: got %h exp 12345678", r_wd); end
        checks++; if (r_lat !== 3) begin errors++; $display("FAIL sw_latency: got %0d exp 3", r_lat); end
        ack_mode = 0;
        run_op(1'b0, 2'b10, 1'b0, 32'h204, 32'h0);
        checks++; if (r_rdata !== 32'h56787800) begin errors++; $display("FAIL rb_204: got %h exp 56787800", r_rdata); end
        run_op(1'b0, 2'b10, 1'b0, 32'h208, 32'h0);
        checks++; if (r_rdata !== 32'h12345678) begin errors++; $display("FAIL rb_208: got %h exp 12345678", r_rdata); end
        run_op(1'b0, 2'b00, 1'b0, 32'h205, 32'h0);
        checks++; if (r_rdata !== 32'h00000078) begin errors++; $display("FAIL rb_lb205: got %h exp 00000078", r_rdata); end
    endtask

    task automatic test_misaligned();
        logic       st [3] = '{1'b0, 1'b1, 1'b1};
        logic [1:0] sz [3] = '{2'b01, 2'b10, 2'b11};
        logic [31:0] ad [3] = '{32'h101, 32'h102, 32'h100};
        ack_mode = 0;
        for (int i = 0; i < 3; i++) begin
            run_op(st[i], sz[i], 1'b0, ad[i], 32'hDEADBEEF);
            checks++; if (r_mis !== 1'b1) begin errors++; $display("FAIL mis_flag[%0d]: got %b exp 1", i, r_mis); end
            checks++; if (r_lat !== 1) begin errors++; $display("FAIL mis_latency[%0d]: got %0d exp 1", i, r_lat); end
            checks++; if (r_reqc !== 0) begin errors++; $display("FAIL mis_req[%0d]: got %0d exp 0", i, r_reqc); end
            checks++; if (r_rdata !== 32'h0) begin errors++; $display("FAIL mis_rdata[%0d]: got %h exp 0", i, r_rdata); end
        end
        run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        checks++; if (r_rdata !== 32'h8899AABB) begin errors++; $display("FAIL mis_mem: got %h exp 8899aabb", r_rdata); end
        checks++; if (r_mis !== 1'b0) begin errors++; $display("FAIL aligned_flag: got %b exp 0", r_mis); end
    endtask

    task automatic test_timeout();
        ack_mode = 2;
        run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        checks++; if (r_reqc !== 4) begin errors++; $display("FAIL to_req_cycles: got %0d exp 4", r_reqc); end
        checks++; if (r_lat !== 5) begin errors++; $display("FAIL to_latency: got %0d exp 5", r_lat); end
        checks++; if (r_to !== 1'b1) begin errors++; $display("FAIL to_flag: got %b exp 1", r_to); end
        checks++; if (r_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h exp 0", r_rdata); end
    endtask

    task automatic test_ack_race();
        ack_mode = 3;
        run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        checks++; if (r_to !== 1'b0) begin errors++; $display("FAIL race_flag: got %b exp 0", r_to); end
        checks++; if (r_rdata !== 32'h8899AABB) begin errors++; $display("FAIL race_rdata: got %h exp 8899aabb", r_rdata); end
        checks++; if (r_lat !== 5) begin errors++; $display("FAIL race_latency: got %0d exp 5", r_lat); end
    endtask

    task automatic test_no_timeout();
        int pulses = 0, drops = 0;
        @(negedge clk);
        op0_valid = 1'b1;
        @(posedge clk);
        #1 op0_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (rsp0_valid) pulses++;
            if (!bus0.req) drops++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL t0_rsp: got %0d pulses exp 0", pulses); end
        checks++; if (drops !== 0) begin errors++; $display("FAIL t0_req: req low %0d cycles exp 0", drops); end
    endtask

    task automatic test_reset_mid_req();
        int pulses = 0;
        ack_mode = 2;
        @(negedge clk);
        op_store = 1'b0; op_size = 2'b10; op_unsigned = 1'b0; op_addr = 32'h100;
        op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL mid_req_before: got %b exp 1", bus.req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL mid_req_async: got %b exp 0", bus.req); end
        checks++; if (bus0.req !== 1'b0) begin errors++; $display("FAIL mid_req0_async: got %b exp 0", bus0.req); end
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_low: got %b exp 0", op_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 if (rsp_valid) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL mid_rsp: got %0d pulses exp 0", pulses); end
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after: got %b exp 1", op_ready); end
        ack_mode = 0;
        run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        checks++; if (r_rdata !== 32'h8899AABB) begin errors++; $display("FAIL post_rst_lw: got %h exp 8899aabb", r_rdata); end
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL post_rst_latency: got %0d exp 2", r_lat); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'h8899AABB;
        test_reset();
        test_loads();
        test_stores();
        test_misaligned();
        test_timeout();
        test_ack_race();
        test_no_timeout();
        test_reset_mid_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_dbus_master.md
# lsu_dbus_master

Initiator side of the data bus: accepts one load/store operation at a time from the execute stage and drives it onto the `type_dbus2peri_s` request interface. It generates byte-lane selects, replicates store data across lanes, waits for the `type_peri2dbus_s` acknowledge, then extracts and sign- or zero-extends load data. Misaligned accesses and acknowledge timeouts are flagged back to execute, and no bus write is performed for them. It sits between the execute stage and the memory/peripheral data bus.

## Interface
- `XLEN`, 32, data/address width.
- `TIMEOUT_CYCLES`, 255, number of cycles in REQ without ack before aborting; 0 disables the timeout.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `op_valid`  in  1  execute presents an operation.
- `op_ready`  out  1  block is idle and can accept an operation.
- `op_store`  in  1  1 = store, 0 = load.
- `op_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `op_unsigned`  in  1  zero-extend the load result (LBU/LHU).
- `op_addr`  in  XLEN  byte address.
- `op_wdata`  in  XLEN  store data, right-aligned.
- `lsu2dbus_o`  out  type_dbus2peri_s  carries `req`, `w_en`, `addr`, `w_data`, `sel_byte`.
- `dbus2lsu_i`  in  type_peri2dbus_s  carries `r_data`, `ack`.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  XLEN  extended load data; 0 for stores and errors.
- `rsp_misaligned`  out  1  valid with `rsp_valid`.
- `rsp_timeout`  out  1  valid with `rsp_valid`.

## Operation
- FSM states IDLE, REQ, RESP. Reset state is IDLE.
- **IDLE**
  - `op_ready`=1.
  - On `op_valid`: latch store, size, unsigned, addr and wdata.
  - Misaligned operation → RESP with `rsp_misaligned`=1. Otherwise → REQ and clear the timeout counter.
- **Misalignment definition**
  - half with `addr[0]`=1;
  - word with `addr[1:0]`≠0;
  - `op_size`=11, always.
- **REQ**
  - Drive `req`=1, `w_en`=store, `addr`={latched addr[XLEN-1:2],2'b00}, plus `sel_byte` and `w_data` as below.
  - On `ack`: capture `r_data` (loads) → RESP.
  - Otherwise increment the counter. When counter == `TIMEOUT_CYCLES`-1 and `TIMEOUT_CYCLES`≠0: → RESP with `rsp_timeout`=1.
- **RESP**
  - `rsp_valid`=1 for exactly one cycle → IDLE.
- **Lane rules**
  - Byte: `sel_byte`=1<<addr[1:0], `w_data`={4{wdata[7:0]}}.
  - Half: `sel_byte`=0011 if addr[1]=0, else 1100; `w_data`={2{wdata[15:0]}}.
  - Word: `sel_byte`=1111, `w_data`=wdata.
- **Load extraction**
  - Byte: the lane at `r_data[8*addr[1:0] +: 8]`.
  - Half: `r_data[16*addr[1] +: 16]`.
  - Sign-extend unless `op_unsigned`. Word loads are passed through unchanged.
- **Ignored inputs**
  - `ack` is ignored in IDLE and RESP.
  - Operation inputs are ignored unless accepted in IDLE.
- Outside REQ, all `lsu2dbus_o` fields are 0.
- In RESP, `rsp_*` fields are registered values. Outside RESP, all `rsp_*` outputs are 0.

## Timing
- Operation accepted in cycle T (`op_valid`&`op_ready`).
- **Load, combinational ack:** `req` high in T+1, ack in T+1, `rsp_valid` in T+2. Accept-to-response latency is 2.
- **Store, registered ack:** `req` high in T+1 and T+2, ack in T+2, `rsp_valid` in T+3. Latency is 3.
  - The memory sees the store request in both cycles. The second write repeats the same data/lanes and is idempotent by design.
- **Misaligned:** `rsp_valid` in T+1, and `req` is never asserted.
- **Timeout:** `req` is held for exactly `TIMEOUT_CYCLES` cycles (T+1..T+N), `rsp_valid` in T+N+1.
- **Simultaneous ack and timeout** in the same cycle: ack wins, `rsp_timeout`=0.
- Next accept is no earlier than the cycle after RESP. Minimum back-to-back load spacing is 3 cycles.
- **Reset (`rst_n` low)**
  - Immediate: state IDLE, `req`=0, `rsp_*`=0, counter=0, latched operation cleared.
  - Reset mid-REQ aborts the transaction with no response pulse.
  - `op_ready` is 0 while `rst_n` is low and becomes 1 after release.

## Test plan
- **Load word, signed byte, unsigned half.** Memory word at 0x100 = 0x8899AABB.
  - LW 0x100 → `rsp_rdata`=0x8899AABB at T+2.
  - LB 0x103 → 0xFFFFFF88.
  - LHU 0x102 → 0x00008899.
- **Store byte/half/word lanes.**
  - SB 0x205 data 0x12345678 → `sel_byte`=0010, `w_data`=0x78787878.
  - SH 0x206 → `sel_byte`=1100, `w_data`=0x56785678.
  - SW → 1111. Each gives `rsp_valid` at T+3.
  - Read-back matches.
- **Misaligned.**
  - LH 0x101, SW 0x102, size=11 → `rsp_misaligned`=1 at T+1.
  - `req` never high; memory contents unchanged.
- **Timeout.** `TIMEOUT_CYCLES`=4, bench never acks.
  - `req` high exactly 4 cycles, then `rsp_timeout`=1 and `rsp_rdata`=0.
  - With `TIMEOUT_CYCLES`=0: no timeout after 1000 cycles.
- **Ack/timeout race.** Ack on the 4th REQ cycle with N=4 → normal response, `rsp_timeout`=0.
- **Reset mid-REQ.** Assert `rst_n` low during a stalled REQ.
  - `req` drops without waiting for a clock edge; no `rsp_valid`.
  - After release, `op_ready`=1 and a following LW completes normally.
